lab3_mem_responder: RTL

Memory-side responder for the cache's downstream port: accepts `mem_req_4B_t` requests on the `cache_req_*` channel and returns `mem_resp_4B_t` responses on the `cache_resp_*` channel after a programmable latency. Backs a word-addressed storage array and serves as the main-memory model behind the blocking and alternate caches in unit and system benches. One transaction is in flight at a time. Responses return in request order.

---
 rtl/lab3_mem_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/lab3_mem_responder.sv
// Word-addressed main-memory model behind the cache's downstream port.
// One transaction in flight; response issued LATENCY+1 cycles after accept.
module lab3_mem_responder #(
    parameter int NUM_WORDS = 256,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cache_req_val,
    output logic        cache_req_rdy,
    input  logic [76:0] cache_req_msg,
    output logic        cache_resp_val,
    input  logic        cache_resp_rdy,
    output logic [46:0] cache_resp_msg,
    output logic [15:0] num_reqs
);

    localparam int AW = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [2:0]      req_type;
    logic [7:0]      req_opq;
    logic [AW-1:0]   req_idx;
    logic [1:0]      req_len;
    logic [31:0]     req_data;
    logic            fresh_q;
    logic [31:0]     rdata_q;
    logic [31:0]     mem [NUM_WORDS];

    logic            accept;
    logic            is_wr;
    logic [31:0]     mask;
    logic [31:0]     word_rd;
    logic [31:0]     merged;
    logic [31:0]     resp_data;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^{cache_req_msg[65:36+AW], cache_req_msg[35:34]};

    assign accept = (state_q == IDLE) && cache_req_val;
    assign is_wr  = (req_type == 3'd1) || (req_type == 3'd2);

    always_comb begin
        mask = 32'hFFFF_FFFF;
        unique case (req_len)
            2'd0: mask = 32'hFFFF_FFFF;
            2'd1: mask = 32'h0000_00FF;
            2'd2: mask = 32'h0000_FFFF;
            2'd3: mask = 32'h00FF_FFFF;
        endcase
    end

    assign word_rd = mem[req_idx] & mask;
    assign merged  = (mem[req_idx] & ~mask) | (req_data & mask);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cache_req_val) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd1) state_d = RESP;
                else cnt_d = cnt_q - 4'd1;
            end
            RESP: begin
                if (cache_resp_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_type <= '0;
            req_opq  <= '0;
            req_idx  <= '0;
            req_len  <= '0;
            req_data <= '0;
            fresh_q  <= 1'b0;
            rdata_q  <= '0;
            num_reqs <= '0;
            for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_type <= cache_req_msg[76:74];
                req_opq  <= cache_req_msg[73:66];
                req_idx  <= cache_req_msg[36 +: AW];
                req_len  <= cache_req_msg[33:32];
                req_data <= cache_req_msg[31:0];
                num_reqs <= num_reqs + 16'd1;
            end
            fresh_q <= (state_d == RESP) && (state_q != RESP);
            // Storage is touched once, at the end of the first RESP cycle
            if (fresh_q) begin
                if (is_wr) mem[req_idx] <= merged;
                else rdata_q <= word_rd;
            end
        end
    end

    assign resp_data = is_wr ? 32'h0 : (fresh_q ? word_rd : rdata_q);

    assign cache_req_rdy  = reset && (state_q == IDLE);
    assign cache_resp_val = reset && (state_q == RESP);
    assign cache_resp_msg = (state_q == RESP)
                          ? {req_type, req_opq, 2'b00, req_len, resp_data}
                          : '0;

endmodule
